e_cpu_io_cfu_sequencer: RTL
===========================

Name: e_cpu_io_cfu_sequencer

Overview:
- Sequences one custom-function (CFU) transaction between the CPU and the east CPU-IO fabric tile.
- Accepts a 32-bit operand pair from the CPU and serialises it onto the 4-bit OPA/OPB lanes, 8 beats, LSB nibble first.
- Waits for the fabric result on RES0/RES1 (8 bits per valid beat, 4 beats), reassembles the 32-bit result and returns it with a valid/ready handshake.
- A cycle timeout guarantees the CPU is never hung by an unconfigured or faulty fabric.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles allowed in WAIT/RECV without a result beat before an error response; legal range 2..65535.
- FUNC_W, 4: width of the function code sent on the first beat.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_opa_i  in  32  operand A.
- req_opb_i  in  32  operand B.
- req_func_i  in  FUNC_W  function code.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  CPU accepts response.
- rsp_data_o  out  32  reassembled result; 0 on error.
- rsp_err_o  out  1  timeout occurred.
- fab_start_o  out  1  one-cycle frame strobe to fabric, coincident with the function beat.
- opa_o  out  4  operand A nibble lane to tile.
- opb_o  out  4  operand B nibble lane to tile.
- res0_i  in  4  result low nibble lane from tile.
- res1_i  in  4  result high nibble lane from tile.
- res2_i  in  4  control lane: [0] result-beat valid, [3:1] ignored.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (wb_rst_i high at a rising edge, any state, mid-transaction included):
  - state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_data_o=0; rsp_err_o=0; fab_start_o=0; opa_o=opb_o=0; busy_o=0.
  - Beat and timeout counters cleared; any in-flight transaction is dropped silently.
- States: IDLE, FUNC, SEND, WAIT, RECV, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch opa/opb/func, go to FUNC.
  - Lanes are driven 0 in IDLE.
- FUNC (1 cycle):
  - fab_start_o=1; opa_o=func[3:0] (zero-extended if FUNC_W<4; FUNC_W>4 bits go to opb_o); opb_o=0 when FUNC_W<=4.
  - Go to SEND, beat=0.
- SEND (8 cycles):
  - opa_o=opa[4*beat+3:4*beat]; opb_o=opb[4*beat+3:4*beat].
  - After beat 7 go to WAIT; timeout counter cleared.
- WAIT/RECV:
  - Lanes driven 0.
  - Each cycle with res2_i[0]=1 captures {res1_i,res0_i} into result bits [8k+7:8k], k=0..3; the timeout counter resets on every captured beat.
  - The first captured beat moves WAIT->RECV; the fourth goes to RESP with err=0.
  - Result beats seen in FUNC/SEND are ignored.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no beat: go to RESP, rsp_err_o=1, rsp_data_o=0.
  - A beat on the same cycle as expiry wins: it is captured and the timeout is cancelled.
- RESP:
  - rsp_valid_o=1; data/err held stable until rsp_ready_i.
  - On the handshake go to IDLE; req_ready_o rises the following cycle, so there is no back-to-back accept in the response cycle.
- req_ready_o=0 in every state except IDLE; a request held during busy waits.
- Latency, ideal fabric (first beat in the cycle after last SEND, contiguous): request accept -> rsp_valid_o = 1 FUNC + 8 SEND + 4 RECV + 1 = 14 cycles.
- All outputs are registered; no combinational path from res*_i to rsp_*.

Decomposition:
- Package e_cpu_io_cfu_pkg:
  - state enum (IDLE..RESP);
  - constants NUM_SEND_BEATS=8, NUM_RECV_BEATS=4, LANE_W=4;
  - timeout counter width function ($clog2(TIMEOUT_CYCLES)).
- One natural sub-module: e_cpu_io_cfu_timeout, a loadable down-counter with clear/expire, reused by other IO-tile controllers.
- Serialiser and deserialiser stay inline.

Test Plan:
- Basic op: opa=0x89ABCDEF, opb=0x01234567, func=0x5; fabric replies after 3 cycles with contiguous beats {res1,res0}=0xEF,0xBE,0xAD,0xDE.
  - fab_start_o with opa_o=5; SEND beats opa_o=F,E,D,C,B,A,9,8 and opb_o=7,6,5,4,3,2,1,0.
  - rsp_data_o=0xDEADBEEF, err=0.
- Gapped result: same beats with 5 idle cycles between beats 1 and 2 -> identical result, no timeout.
- Timeout: TIMEOUT_CYCLES=16, no res2_i[0] ever -> RESP exactly 16 cycles after WAIT entry; rsp_err_o=1, rsp_data_o=0.
- Backpressure: rsp_ready_i low for 10 cycles -> data/err stable; new req_valid_i held meanwhile is accepted only after the handshake plus 1 cycle.
- Reset mid-SEND (beat 4) -> next cycle all outputs at reset values; a fresh request then completes normally.
- Spurious beats: res2_i[0]=1 during FUNC/SEND -> ignored; result is formed only from beats after SEND.

Source files
------------

// File: rtl/e_cpu_io_cfu_pkg.sv
// Shared types and constants for the east CPU-IO custom-function sequencer.
package e_cpu_io_cfu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FUNC,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_RESP
  } cfu_state_e;

  localparam int NUM_SEND_BEATS = 8;
  localparam int NUM_RECV_BEATS = 4;
  localparam int LANE_W         = 4;

  // Counter width able to hold TIMEOUT_CYCLES-1; never narrower than one bit.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/e_cpu_io_cfu_timeout.sv
// Loadable down-counter: load restarts the window, dec counts it down, expired_o
// flags the terminal count. Shared by the IO-tile controllers.
module e_cpu_io_cfu_timeout #(
  parameter int unsigned LOAD_VAL = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/e_cpu_io_cfu_sequencer.sv
// Runs one CFU transaction: serialises the operand pair onto the nibble lanes,
// gathers four result bytes from the tile and returns them, with a timeout guard.
module e_cpu_io_cfu_sequencer
  import e_cpu_io_cfu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned FUNC_W         = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [31:0]         req_opa_i,
  input  logic [31:0]         req_opb_i,
  input  logic [FUNC_W-1:0]   req_func_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_data_o,
  output logic                rsp_err_o,
  output logic                fab_start_o,
  output logic [LANE_W-1:0]   opa_o,
  output logic [LANE_W-1:0]   opb_o,
  input  logic [LANE_W-1:0]   res0_i,
  input  logic [LANE_W-1:0]   res1_i,
  input  logic [LANE_W-1:0]   res2_i,
  output logic                busy_o
);

  localparam int TMO_W      = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam int FUNC_PAD_W = 2 * LANE_W;

  cfu_state_e  state_q, state_d;
  logic [2:0]  beat_q, beat_d, beat_nxt;
  logic        req_ready_q, busy_q, fab_start_q, rsp_valid_q, rsp_err_q;
  logic        fab_start_d, rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [LANE_W-1:0] opa_q, opb_q, opa_d, opb_d;
  logic [31:0] opa_lat_q, opb_lat_q;
  logic [23:0] result_q;
  logic        accept, capture, tmo_load, tmo_dec, tmo_expired;
  logic [FUNC_PAD_W-1:0] func_pad;
  logic        res2_unused;

  assign accept      = (state_q == ST_IDLE) && req_valid_i && req_ready_q;
  assign beat_nxt    = beat_q + 3'd1;
  assign func_pad    = FUNC_PAD_W'(req_func_i);
  assign res2_unused = ^res2_i[LANE_W-1:1];

  e_cpu_io_cfu_timeout #(
    .LOAD_VAL (TIMEOUT_CYCLES - 1),
    .CNT_W    (TMO_W)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .load_i    (tmo_load),
    .dec_i     (tmo_dec),
    .expired_o (tmo_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    opa_d       = '0;
    opb_d       = '0;
    fab_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    capture     = 1'b0;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;

    // Lane outputs are computed one cycle early so they leave the block registered.
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_FUNC;
          fab_start_d = 1'b1;
          opa_d       = func_pad[LANE_W-1:0];
          opb_d       = func_pad[FUNC_PAD_W-1:LANE_W];
        end
      end
      ST_FUNC: begin
        state_d = ST_SEND;
        beat_d  = '0;
        opa_d   = opa_lat_q[LANE_W-1:0];
        opb_d   = opb_lat_q[LANE_W-1:0];
      end
      ST_SEND: begin
        if (beat_q == 3'(NUM_SEND_BEATS - 1)) begin
          state_d  = ST_WAIT;
          beat_d   = '0;
          tmo_load = 1'b1;
        end else begin
          beat_d = beat_nxt;
          opa_d  = opa_lat_q[{beat_nxt, 2'b00} +: LANE_W];
          opb_d  = opb_lat_q[{beat_nxt, 2'b00} +: LANE_W];
        end
      end
      ST_WAIT, ST_RECV: begin
        // A beat arriving on the expiry cycle takes priority over the timeout.
        if (res2_i[0]) begin
          capture  = 1'b1;
          tmo_load = 1'b1;
          beat_d   = beat_nxt;
          state_d  = ST_RECV;
          if (beat_q == 3'(NUM_RECV_BEATS - 1)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {res1_i, res0_i, result_q};
            rsp_err_d   = 1'b0;
          end
        end else if (tmo_expired) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      fab_start_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      fab_start_q <= fab_start_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: pure datapath holding registers carry no reset; each is written
  // before it is read within a transaction.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      opa_lat_q <= req_opa_i;
      opb_lat_q <= req_opb_i;
    end
    if (capture) begin
      unique case (beat_q[1:0])
        2'd0:    result_q[7:0]   <= {res1_i, res0_i};
        2'd1:    result_q[15:8]  <= {res1_i, res0_i};
        2'd2:    result_q[23:16] <= {res1_i, res0_i};
        default: ;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign busy_o      = busy_q;
  assign fab_start_o = fab_start_q;
  assign opa_o       = opa_q;
  assign opb_o       = opb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
